// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum drain path.
//   drain_state_e : drain FSM states
//   DEF_*         : default widths/depth for the drain and requantiser
//   sat_signed()  : clamp a wide signed value into a signed out_w-bit range
package psum_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    localparam int unsigned DEF_STAGE_NUM  = 16;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_OUT_WIDTH  = 8;

    // Working width for saturation; wide enough for any DATA_WIDTH+1 input.
    localparam int unsigned SAT_IN_W = 64;

    function automatic logic signed [SAT_IN_W-1:0] sat_signed(
        input logic signed [SAT_IN_W-1:0] v,
        input int unsigned                out_w
    );
        logic signed [SAT_IN_W-1:0] hi;
        logic signed [SAT_IN_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/psum_drain_if.sv
// Downstream result stream of psum_drain (valid/ready).
//   out_data_o  : requantised signed result
//   out_idx_o   : accumulator index of out_data_o
//   out_last_o  : final beat of the tile
//   out_valid_o : beat valid
//   out_ready_i : downstream ready
// master = drain side, slave = output writer side.
interface psum_drain_if
    import psum_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int unsigned STAGE_NUM = DEF_STAGE_NUM
);
    localparam int unsigned PTR_W = $clog2(STAGE_NUM);

    logic [OUT_WIDTH-1:0] out_data_o;
    logic [PTR_W-1:0]     out_idx_o;
    logic                 out_last_o;
    logic                 out_valid_o;
    logic                 out_ready_i;

    modport master (
        output out_data_o, out_idx_o, out_last_o, out_valid_o,
        input  out_ready_i
    );

    modport slave (
        input  out_data_o, out_idx_o, out_last_o, out_valid_o,
        output out_ready_i
    );
endinterface

// File: rtl/psum_drain_requant_sat.sv
// requant_sat: combinational round-half-up right shift followed by signed saturation.
//   x_i     : signed DATA_WIDTH input
//   shift_i : right-shift amount (0 = pass through)
//   y_o     : signed OUT_WIDTH saturated result
module requant_sat
    import psum_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
    localparam int unsigned SH_W       = $clog2(DATA_WIDTH)
) (
    input  logic signed [DATA_WIDTH-1:0] x_i,
    input  logic        [SH_W-1:0]       shift_i,
    output logic signed [OUT_WIDTH-1:0]  y_o
);

    // One extra bit so the rounding add can never overflow.
    logic signed [DATA_WIDTH:0] x_ext;
    logic signed [DATA_WIDTH:0] rnd;
    logic signed [DATA_WIDTH:0] y_pre;
    logic signed [SAT_IN_W-1:0] y_sat;

    always_comb begin
        x_ext = {x_i[DATA_WIDTH-1], x_i};
        rnd   = '0;
        y_pre = x_ext;
        if (shift_i != '0) begin
            rnd   = (DATA_WIDTH+1)'(1) << (shift_i - SH_W'(1));
            y_pre = (x_ext + rnd) >>> shift_i;
        end
        y_sat = sat_signed(SAT_IN_W'(y_pre), OUT_WIDTH);
        y_o   = y_sat[OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/psum_drain.sv
// psum_drain: on a rising edge of accumulator completion, sweeps read_ptr_o over the
// accumulator, requantises each psum and streams it out on a valid/ready interface.
//   clk, rst      : clock, synchronous active-high reset
//   acc_data_i    : accumulator data at read_ptr_o (combinational)
//   acc_done_i    : accumulator calc done
//   acc_valid_i   : accumulator output valid
//   read_ptr_o    : accumulator read pointer
//   drain_len_i   : entries to drain (0 means STAGE_NUM)
//   shift_i       : requant right-shift amount
//   busy_o        : drain in progress
//   overrun_o     : sticky, tile completion seen while busy
//   out_if        : result stream (master side)
module psum_drain
    import psum_pkg::*;
#(
    parameter  int unsigned STAGE_NUM  = DEF_STAGE_NUM,
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
    localparam int unsigned PTR_W      = $clog2(STAGE_NUM),
    localparam int unsigned SH_W       = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] acc_data_i,
    input  logic                  acc_done_i,
    input  logic                  acc_valid_i,
    output logic [PTR_W-1:0]      read_ptr_o,
    input  logic [PTR_W:0]        drain_len_i,
    input  logic [SH_W-1:0]       shift_i,
    output logic                  busy_o,
    output logic                  overrun_o,
    psum_drain_if.master          out_if
);

    drain_state_e         state_q, state_d;
    logic                 trig_prev_q, trig_prev_d;
    logic [PTR_W:0]       len_q, len_d;
    logic [SH_W-1:0]      shift_q, shift_d;
    logic [PTR_W:0]       cnt_q, cnt_d;
    logic [PTR_W-1:0]     read_ptr_q, read_ptr_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [PTR_W-1:0]     out_idx_q, out_idx_d;
    logic                 out_last_q, out_last_d;
    logic                 out_valid_q, out_valid_d;

    logic                 trig_raw;
    logic                 trigger;
    logic                 load;
    logic                 at_last;
    logic [OUT_WIDTH-1:0] rq_y;

    requant_sat #(
        .DATA_WIDTH(DATA_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_requant (
        .x_i    (acc_data_i),
        .shift_i(shift_q),
        .y_o    (rq_y)
    );

    always_comb begin
        trig_raw    = acc_done_i & acc_valid_i;
        trigger     = trig_raw & ~trig_prev_q;
        load        = ~out_valid_q | out_if.out_ready_i;
        at_last     = ({1'b0, read_ptr_q} == (len_q - (PTR_W+1)'(1)));

        state_d     = state_q;
        trig_prev_d = trig_raw;
        len_d       = len_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        read_ptr_d  = read_ptr_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                read_ptr_d = '0;
                if (trigger) begin
                    len_d   = (drain_len_i == '0) ? (PTR_W+1)'(STAGE_NUM) : drain_len_i;
                    shift_d = shift_i;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (trigger) begin
                    overrun_d = 1'b1;
                end
                if (load) begin
                    if (cnt_q < len_q) begin
                        out_data_d  = rq_y;
                        out_idx_d   = read_ptr_q;
                        out_valid_d = 1'b1;
                        out_last_d  = at_last;
                        cnt_d       = cnt_q + (PTR_W+1)'(1);
                        // Pointer parks on len-1 rather than wrapping past the tile.
                        if (!at_last) begin
                            read_ptr_d = read_ptr_q + PTR_W'(1);
                        end
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                    // A load with a valid beat present is the handshake itself.
                    if (out_valid_q && out_last_q) begin
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        read_ptr_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            trig_prev_q <= 1'b0;
            len_q       <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            read_ptr_q  <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_prev_q <= trig_prev_d;
            len_q       <= len_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            read_ptr_q  <= read_ptr_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign read_ptr_o         = read_ptr_q;
    assign busy_o             = busy_q;
    assign overrun_o          = overrun_q;
    assign out_if.out_data_o  = out_data_q;
    assign out_if.out_idx_o   = out_idx_q;
    assign out_if.out_last_o  = out_last_q;
    assign out_if.out_valid_o = out_valid_q;

endmodule
